difftest_step_scheduler: RTL and testbench
==========================================

Name: difftest_step_scheduler

Overview:
- Coalesces per-cycle commit counts (difftest_step) from the DUT into batched step requests toward the simulation endpoint's step/check shim.
- Issues a request when a batch threshold is reached, an idle timeout expires or a flush is requested, then waits for the check result.
- Latches a non-zero result (DONE=0x01, FAIL=0x02) sticky so the endpoint can finish or dump.
- Sits between the DUT step output and the endpoint's step/result interface.

Parameters:
- STEP_W, 8, width of the per-cycle step input (matches CONFIG_DIFFTEST_STEPWIDTH).
- ACC_W, 16, accumulator and request-step width.
- TMO_W, 16, idle-timeout counter width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- step_in  in  STEP_W  instructions committed this cycle.
- cfg_batch  in  ACC_W  batch threshold; 0 is treated as 1.
- cfg_timeout  in  TMO_W  idle cycles before a forced flush; 0 disables the timeout.
- flush  in  1  single-cycle force-issue pulse.
- req_valid  out  1  step request valid.
- req_step  out  ACC_W  step count carried by the request.
- req_ready  in  1  shim accepts the request.
- resp_valid  in  1  check result valid (1-cycle pulse).
- resp_result  in  8  0 = continue; otherwise DONE/FAIL code.
- result_out  out  8  sticky result.
- busy  out  1  state is ISSUE or WAIT.
- stall  out  1  accumulator is within 2^STEP_W-1 of saturation.
- ovf  out  1  sticky: saturation occurred.
- issued_total  out  64  sum of req_step over all handshakes.

Behaviour:
- Reset (reset low, asynchronous):
  - state=ACCUM.
  - acc=0, idle_cnt=0.
  - req_valid=0, req_step=0, result_out=0.
  - busy=0, stall=0, ovf=0, issued_total=0.
- Definitions:
  - sum = sat(acc + step_in), saturating at 2^ACC_W-1; ovf is set when saturation clips.
  - bt = max(cfg_batch, 1).
- ACCUM state:
  - Launch L = sum!=0 AND (sum>=bt OR flush OR (cfg_timeout!=0 AND idle_cnt>=cfg_timeout)).
  - If L: req_step<=sum, acc<=0, idle_cnt<=0, req_valid<=1, go to ISSUE. req_valid is high the cycle after the launching step_in (latency 1).
  - Else: acc<=sum; idle_cnt<=sat(idle_cnt+1) if sum!=0, else idle_cnt<=0.
  - flush with sum==0 is ignored.
- ISSUE state:
  - req_valid=1, req_step held stable.
  - On req_ready: req_valid<=0, issued_total<=issued_total+req_step, go to WAIT.
- WAIT state:
  - On resp_valid with resp_result==0: go to ACCUM, idle_cnt<=0.
  - On resp_valid with resp_result!=0: result_out<=resp_result, go to HALT.
- ISSUE and WAIT: acc<=sum (steps keep accumulating); no launch is evaluated.
- HALT state:
  - Absorbing until reset.
  - acc, issued_total and result_out frozen; req_valid=0; step_in, flush and resp ignored.
- resp_valid outside WAIT: ignored.
- Simultaneous req_ready and resp_valid in ISSUE: the handshake is taken; resp is ignored.
- stall is combinational: acc > (2^ACC_W-1) - (2^STEP_W-1). It is advisory; the core is expected to stop stepping while it is high.
- Reset asserted mid-ISSUE/WAIT drops req_valid immediately (asynchronous); any in-flight request is abandoned.
- All arithmetic is unsigned. issued_total wraps at 2^64.

Decomposition:
- Shared package (difftest_sched_pkg): state enum {ACCUM, ISSUE, WAIT, HALT}; constants SIMV_DONE=8'h01 and SIMV_FAIL=8'h02; a saturating-add function.
- One sub-module is natural: difftest_sat_acc (saturating accumulator with ovf flag), reused for acc and idle_cnt.
- The FSM stays inline.

Test Plan:
- Batch threshold: cfg_batch=4, cfg_timeout=0, step_in=1 for 4 cycles, req_ready=1 → req_valid high for 1 cycle after the 4th step, req_step=4, issued_total=4, busy=1 until resp.
- Idle timeout: cfg_batch=100, cfg_timeout=3, single step_in=2 then zeros → launch after idle_cnt reaches 3, req_step=2. Repeat with cfg_timeout=0 → no request.
- Backpressure with continued accumulation: req_ready held 0 for 3 cycles while step_in=1 each cycle; then ready; resp=0 → first req_step unchanged; acc=3 on return to ACCUM; next launch includes those 3.
- Failure halt: resp_result=8'h02 → result_out=0x02 sticky; further steps/flush give no req_valid; issued_total frozen.
- Flush semantics: flush with acc=0 → nothing. flush with acc=5 → req_step=5 the next cycle.
- Saturation and reset: ACC_W=8, STEP_W=8, cfg_batch=255, accumulate 200+100 → req_step=255, ovf=1, stall asserted beforehand. Then drop reset during WAIT → all outputs 0 immediately; state ACCUM after release.

Source files
------------

// File: rtl/difftest_step_scheduler_pkg.sv
// Shared types and helpers for the difftest step scheduler: FSM states,
// endpoint result codes and a saturating add used by the accumulators.
package difftest_sched_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } sched_state_e;

    localparam logic [7:0] SIMV_DONE = 8'h01;
    localparam logic [7:0] SIMV_FAIL = 8'h02;

    // Returns {clipped, sat(a + b)} where the result saturates at 2^w-1 (w <= 64).
    function automatic logic [64:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] mx;
        logic [64:0] s;
        if (w >= 32'd64) begin
            mx = {64{1'b1}};
        end else begin
            mx = (64'd1 << w) - 64'd1;
        end
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, mx}) begin
            return {1'b1, mx};
        end else begin
            return {1'b0, s[63:0]};
        end
    endfunction

endpackage

// File: rtl/difftest_step_scheduler_sat_acc.sv
// Combinational saturating adder stage: next value of a W-bit accumulator
// plus an IN_W-bit increment, with a flag raised when the sum is clipped.
module difftest_sat_acc
    import difftest_sched_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned IN_W = 8
) (
    input  logic [W-1:0]    acc,
    input  logic [IN_W-1:0] inc,
    output logic [W-1:0]    sum,
    output logic            clip
);

    logic [64:0] res_s;
    logic        unused_res_s;

    // Widen both operands to the helper's 64-bit domain and narrow back.
    always_comb begin
        res_s        = sat_add(64'(acc), 64'(inc), W);
        sum          = res_s[W-1:0];
        clip         = res_s[64];
        unused_res_s = ^res_s;
    end

endmodule

// File: rtl/difftest_step_scheduler.sv
// Coalesces per-cycle commit counts into batched step requests for the
// difftest endpoint and latches the first non-zero check result.
module difftest_step_scheduler
    import difftest_sched_pkg::*;
#(
    parameter int unsigned STEP_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned TMO_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [STEP_W-1:0] step_in,
    input  logic [ACC_W-1:0]  cfg_batch,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic              flush,
    output logic              req_valid,
    output logic [ACC_W-1:0]  req_step,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [7:0]        resp_result,
    output logic [7:0]        result_out,
    output logic              busy,
    output logic              stall,
    output logic              ovf,
    output logic [63:0]       issued_total
);

    localparam logic [ACC_W-1:0] ACC_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] STALL_LIM = {ACC_W{1'b1}} - ACC_W'({STEP_W{1'b1}});

    sched_state_e      state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [TMO_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              req_valid_q, req_valid_d;
    logic [ACC_W-1:0]  req_step_q, req_step_d;
    logic [7:0]        result_q, result_d;
    logic              ovf_q, ovf_d;
    logic [63:0]       issued_q, issued_d;

    logic [ACC_W-1:0]  sum_s;
    logic              sum_clip_s;
    logic [TMO_W-1:0]  idle_inc_s;
    logic              idle_clip_unused_s;
    logic [ACC_W-1:0]  bt_s;
    logic              launch_s;

    difftest_sat_acc #(.W(ACC_W), .IN_W(STEP_W)) u_acc_add (
        .acc  (acc_q),
        .inc  (step_in),
        .sum  (sum_s),
        .clip (sum_clip_s)
    );

    difftest_sat_acc #(.W(TMO_W), .IN_W(1)) u_idle_add (
        .acc  (idle_cnt_q),
        .inc  (1'b1),
        .sum  (idle_inc_s),
        .clip (idle_clip_unused_s)
    );

    // Launch decision: threshold, flush or idle timeout, never with an empty batch.
    always_comb begin
        bt_s     = (cfg_batch == {ACC_W{1'b0}}) ? ACC_ONE : cfg_batch;
        launch_s = (sum_s != {ACC_W{1'b0}}) &&
                   ((sum_s >= bt_s) || flush ||
                    ((cfg_timeout != {TMO_W{1'b0}}) && (idle_cnt_q >= cfg_timeout)));
    end

    // Next-state and datapath updates for the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idle_cnt_d  = idle_cnt_q;
        req_valid_d = req_valid_q;
        req_step_d  = req_step_q;
        result_d    = result_q;
        issued_d    = issued_q;
        if ((state_q != ST_HALT) && sum_clip_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            ST_ACCUM: begin
                if (launch_s) begin
                    req_step_d  = sum_s;
                    acc_d       = {ACC_W{1'b0}};
                    idle_cnt_d  = {TMO_W{1'b0}};
                    req_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    acc_d      = sum_s;
                    idle_cnt_d = (sum_s != {ACC_W{1'b0}}) ? idle_inc_s : {TMO_W{1'b0}};
                end
            end
            ST_ISSUE: begin
                acc_d = sum_s;
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    issued_d    = issued_q + 64'(req_step_q);
                    state_d     = ST_WAIT;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                acc_d = sum_s;
                if (resp_valid) begin
                    if (resp_result == 8'h00) begin
                        idle_cnt_d = {TMO_W{1'b0}};
                        state_d    = ST_ACCUM;
                    end else begin
                        result_d = resp_result;
                        state_d  = ST_HALT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HALT: begin
                req_valid_d = 1'b0;
                state_d     = ST_HALT;
            end
            default: begin
                req_valid_d = 1'b0;
                state_d     = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {ACC_W{1'b0}};
            idle_cnt_q  <= {TMO_W{1'b0}};
            req_valid_q <= 1'b0;
            req_step_q  <= {ACC_W{1'b0}};
            result_q    <= 8'h00;
            ovf_q       <= 1'b0;
            issued_q    <= 64'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idle_cnt_q  <= idle_cnt_d;
            req_valid_q <= req_valid_d;
            req_step_q  <= req_step_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            issued_q    <= issued_d;
        end
    end

    assign req_valid    = req_valid_q;
    assign req_step     = req_step_q;
    assign result_out   = result_q;
    assign ovf          = ovf_q;
    assign issued_total = issued_q;
    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    // Advisory back-pressure: one more maximal step could clip the accumulator.
    assign stall        = (acc_q > STALL_LIM);

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// each cycle against a flag-and-integer reference model of the scheduler.
module tb_difftest_step_scheduler;

    localparam longint MAXA = 65535;
    localparam longint MAXT = 65535;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  step_in;
    logic [15:0] cfg_batch;
    logic [15:0] cfg_timeout;
    logic        flush;
    logic        req_valid;
    logic [15:0] req_step;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_result;
    logic [7:0]  result_out;
    logic        busy;
    logic        stall;
    logic        ovf;
    logic [63:0] issued_total;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint      m_acc, m_idle, m_req_step;
    logic [63:0] m_issued;
    bit          m_rv, m_waiting, m_halted, m_ovf;
    logic [7:0]  m_res;

    difftest_step_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .step_in      (step_in),
        .cfg_batch    (cfg_batch),
        .cfg_timeout  (cfg_timeout),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_step     (req_step),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_result  (resp_result),
        .result_out   (result_out),
        .busy         (busy),
        .stall        (stall),
        .ovf          (ovf),
        .issued_total (issued_total)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_idle = 0; m_req_step = 0; m_issued = 64'd0;
        m_rv = 1'b0; m_waiting = 1'b0; m_halted = 1'b0; m_ovf = 1'b0; m_res = 8'h00;
    endtask

    // One clock of the scheduler rules, using the inputs currently driven.
    task automatic model_step();
        longint raw, sum, bt;
        bit     launch;
        if (m_halted) return;
        raw = m_acc + longint'(step_in);
        sum = (raw > MAXA) ? MAXA : raw;
        if (raw > MAXA) m_ovf = 1'b1;
        if (!m_rv && !m_waiting) begin
            bt = (cfg_batch == 16'd0) ? 1 : longint'(cfg_batch);
            launch = (sum != 0) && (sum >= bt || flush ||
                     (cfg_timeout != 16'd0 && m_idle >= longint'(cfg_timeout)));
            if (launch) begin
                m_req_step = sum; m_acc = 0; m_idle = 0; m_rv = 1'b1;
            end else begin
                m_acc  = sum;
                m_idle = (sum != 0) ? ((m_idle + 1 > MAXT) ? MAXT : m_idle + 1) : 0;
            end
        end else if (m_rv) begin
            m_acc = sum;
            if (req_ready) begin
                m_rv = 1'b0; m_issued = m_issued + 64'(m_req_step); m_waiting = 1'b1;
            end
        end else begin
            m_acc = sum;
            if (resp_valid) begin
                m_waiting = 1'b0;
                if (resp_result == 8'h00) m_idle = 0;
                else begin m_res = resp_result; m_halted = 1'b1; end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("req_valid", 64'(req_valid), 64'(m_rv));
        check_eq("req_step", 64'(req_step), 64'(m_req_step));
        check_eq("result_out", 64'(result_out), 64'(m_res));
        check_eq("busy", 64'(busy), 64'(m_rv || m_waiting));
        check_eq("stall", 64'(stall), 64'(m_acc > (MAXA - 255)));
        check_eq("ovf", 64'(ovf), 64'(m_ovf));
        check_eq("issued_total", issued_total, m_issued);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        step_in = 8'd0; flush = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_result = 8'h00;
    endtask

    // Accept the pending request, then return the given check result.
    task automatic handshake_resp(input logic [7:0] res);
        step_in = 8'd0; req_ready = 1'b1; cyc();
        req_ready = 1'b0; resp_valid = 1'b1; resp_result = res; cyc();
        resp_valid = 1'b0; resp_result = 8'h00;
    endtask

    // Asynchronous reset pulse, checked immediately, released away from the edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int lat;
        reset = 1'b0;
        idle_inputs();
        cfg_batch = 16'd4; cfg_timeout = 16'd0;
        #2;
        model_reset();
        compare_all();
        #10;
        reset = 1'b1;

        // Batch threshold
        step_in = 8'd1; req_ready = 1'b1;
        repeat (4) cyc();
        check_eq("batch_rv", 64'(req_valid), 64'd1);
        check_eq("batch_step", 64'(req_step), 64'd4);
        step_in = 8'd0; cyc();
        check_eq("batch_issued", issued_total, 64'd4);
        check_eq("batch_busy", 64'(busy), 64'd1);
        req_ready = 1'b0; resp_valid = 1'b1; cyc();
        resp_valid = 1'b0;
        check_eq("batch_done", 64'(busy), 64'd0);

        // Backpressure with continued accumulation
        step_in = 8'd1;
        repeat (4) cyc();
        repeat (3) cyc();
        check_eq("bp_hold", 64'(req_step), 64'd4);
        handshake_resp(8'h00);
        step_in = 8'd1; cyc();
        check_eq("bp_relaunch", 64'(req_step), 64'd4);
        handshake_resp(8'h00);

        // Idle timeout
        cfg_batch = 16'd100; cfg_timeout = 16'd3;
        step_in = 8'd2; cyc();
        step_in = 8'd0;
        lat = 1;
        while (!req_valid && lat < 12) begin cyc(); lat++; end
        check_eq("tmo_latency", 64'(lat), 64'd4);
        check_eq("tmo_step", 64'(req_step), 64'd2);
        handshake_resp(8'h00);
        cfg_timeout = 16'd0;
        step_in = 8'd2; cyc();
        step_in = 8'd0; repeat (8) cyc();
        check_eq("tmo_off", 64'(req_valid), 64'd0);

        // Flush semantics
        flush = 1'b1; cyc(); flush = 1'b0;
        check_eq("flush_pending", 64'(req_step), 64'd2);
        handshake_resp(8'h00);
        flush = 1'b1; cyc(); flush = 1'b0;
        check_eq("flush_empty", 64'(req_valid), 64'd0);
        step_in = 8'd5; cyc();
        step_in = 8'd0; flush = 1'b1; cyc(); flush = 1'b0;
        check_eq("flush_five", 64'(req_step), 64'd5);

        // Failure halt
        handshake_resp(difftest_sched_pkg::SIMV_FAIL);
        check_eq("halt_result", 64'(result_out), 64'd2);
        for (int i = 0; i < 10; i++) begin
            step_in = 8'($urandom_range(0, 9)); flush = 1'(i & 1);
            req_ready = 1'b1; resp_valid = 1'b1; cyc();
        end
        idle_inputs();
        check_eq("halt_rv", 64'(req_valid), 64'd0);
        check_eq("halt_issued", issued_total, 64'd21);

        // Saturation, stall, then reset during WAIT
        do_reset();
        cfg_batch = 16'hFFFF; cfg_timeout = 16'd0;
        step_in = 8'd200;
        repeat (327) cyc();
        check_eq("sat_stall", 64'(stall), 64'd1);
        check_eq("sat_no_ovf", 64'(ovf), 64'd0);
        cyc();
        check_eq("sat_step", 64'(req_step), 64'hFFFF);
        check_eq("sat_ovf", 64'(ovf), 64'd1);
        step_in = 8'd0; req_ready = 1'b1; cyc(); req_ready = 1'b0;
        check_eq("sat_wait", 64'(busy), 64'd1);
        do_reset();
        flush = 1'b1; cyc(); flush = 1'b0;
        check_eq("post_reset_rv", 64'(req_valid), 64'd0);

        // Randomized traffic
        for (int r = 0; r < 5; r++) begin
            do_reset();
            cfg_batch   = 16'($urandom_range(0, 20));
            cfg_timeout = 16'($urandom_range(0, 5));
            for (int c = 0; c < 300; c++) begin
                step_in     = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                           : 8'($urandom_range(0, 3));
                flush       = ($urandom_range(0, 15) == 0);
                req_ready   = 1'($urandom_range(0, 1));
                resp_valid  = ($urandom_range(0, 2) == 0);
                resp_result = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(1, 2)) : 8'h00;
                cyc();
            end
            idle_inputs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
